// File: rtl/alu_pkg.sv
// Shared constants and types for the integer ALU execute stage.
package alu_pkg;
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // Op code is {funct7[5], funct3}
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // One entry of the output pipeline (M or S register)
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            illegal;
    } alu_resp_t;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and illegal flag from (op, rs1, rs2).
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    srl_y;

    assign shamt = rs2[SHAMT_W-1:0];

    alu_srl u_srl (
        .a     (rs1),
        .shamt (shamt),
        .y     (srl_y)
    );

    // Operation select; unknown codes yield zero and flag illegal
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = rs1 + rs2;
            OP_SUB:  result = rs1 - rs2;
            OP_SLL:  result = rs1 << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            OP_XOR:  result = rs1 ^ rs2;
            OP_SRL:  result = srl_y;
            OP_SRA:  result = XLEN'($signed(rs1) >>> shamt);
            OP_OR:   result = rs1 | rs2;
            OP_AND:  result = rs1 & rs2;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_srl.sv
// Logical right shifter used by the ALU core.
module alu_srl
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    y
);
    assign y = a >> shamt;
endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: main register M plus skid register S so
// downstream backpressure never reaches in_ready combinationally.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd_addr,
    output logic            out_illegal,
    output logic [31:0]     op_count
);
    alu_resp_t       m_q, s_q, new_resp;
    logic            m_full, s_full;
    logic [XLEN-1:0] core_result;
    logic            core_illegal;
    logic            accept, xfer;

    alu_core u_core (
        .op      (in_op),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .result  (core_result),
        .illegal (core_illegal)
    );

    assign new_resp = '{result: core_result, rd: in_rd_addr, illegal: core_illegal};
    assign accept   = in_valid && in_ready;
    assign xfer     = m_full && out_ready;

    // s_full is a flop, so in_ready is a registered output
    assign in_ready    = !s_full;
    assign out_valid   = m_full;
    assign out_result  = m_q.result;
    assign out_rd_addr = m_q.rd;
    assign out_illegal = m_q.illegal;

    // M/S occupancy and data; S can only fill while M is stalled, and
    // in_ready=0 while S is full, so accept and S->M never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            s_full <= 1'b0;
            m_q    <= '0;
            s_q    <= '0;
        end else if (xfer) begin
            if (s_full) begin
                m_q    <= s_q;
                s_full <= 1'b0;
            end else if (accept) begin
                m_q <= new_resp;
            end else begin
                m_full <= 1'b0;
            end
        end else if (accept) begin
            if (m_full) begin
                s_q    <= new_resp;
                s_full <= 1'b1;
            end else begin
                m_q    <= new_resp;
                m_full <= 1'b1;
            end
        end
    end

    // Count of results handed to writeback, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count <= '0;
        else if (xfer) op_count <= op_count + 32'd1;
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_rs1, in_rs2;
    logic [4:0]  in_rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;
    logic [31:0] op_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd_addr  (in_rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd_addr (out_rd_addr),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op with out_ready=1: check it one cycle after accept, then drain it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input logic exp_ill);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd_addr = rd;
        step();
        in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, out_result, exp);
        chk({tag, "_ill"}, 32'(out_illegal), 32'(exp_ill));
        chk({tag, "_rd"},  32'(out_rd_addr), 32'(rd));
        step();
        exp_cnt++;
        chk({tag, "_cnt"}, op_count, 32'(exp_cnt));
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd_addr = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_rd", 32'(out_rd_addr), 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_cnt", op_count, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("srl_2_1",    4'b0101, 32'd2,        32'd1,    5'd1, 32'd1,        1'b0);
        run_op("srl_ff_1",   4'b0101, 32'hFFFFFFFF, 32'd1,    5'd2, 32'h7FFFFFFF, 1'b0);
        run_op("sra_8_4",    4'b1101, 32'h80000000, 32'd4,    5'd3, 32'hF8000000, 1'b0);
        run_op("srl_8_4",    4'b0101, 32'h80000000, 32'd4,    5'd4, 32'h08000000, 1'b0);
        run_op("srl_amt25",  4'b0101, 32'h80000000, 32'h25,   5'd5, 32'h04000000, 1'b0);
        run_op("sll_amt25",  4'b0001, 32'd1,        32'h25,   5'd6, 32'h00000020, 1'b0);
        run_op("sra_amt0",   4'b1101, 32'h8000_1234, 32'h20,  5'd7, 32'h80001234, 1'b0);
        run_op("add_wrap",   4'b0000, 32'hFFFFFFFF, 32'd1,    5'd8, 32'd0,        1'b0);
        run_op("sub_wrap",   4'b1000, 32'd0,        32'd1,    5'd9, 32'hFFFFFFFF, 1'b0);
        run_op("slt_neg",    4'b0010, 32'hFFFFFFFF, 32'd1,    5'd10, 32'd1,       1'b0);
        run_op("sltu_big",   4'b0011, 32'hFFFFFFFF, 32'd1,    5'd11, 32'd0,       1'b0);
        run_op("xor",        4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 32'h0FF00FF0, 1'b0);
        run_op("or",         4'b0110, 32'h0000F000, 32'h0000000F, 5'd13, 32'h0000F00F, 1'b0);
        run_op("and",        4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd14, 32'hF000F000, 1'b0);
        run_op("illegal",    4'b1001, 32'd5,        32'd6,    5'd15, 32'd0,       1'b1);
        run_op("post_ill",   4'b0000, 32'd5,        32'd6,    5'd16, 32'd11,      1'b0);

        // Backpressure: fresh count, 3 ops with out_ready held low 3 cycles
        rst_n = 1'b0; #2; rst_n = 1'b1;
        chk("bp_cnt0", op_count, 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'b0000; in_rs1 = 32'd1; in_rs2 = 32'd2; in_rd_addr = 5'd1;
        step();  // A -> M
        chk("bp_a_vld", 32'(out_valid), 32'd1);
        chk("bp_a_res", out_result, 32'd3);
        chk("bp_a_rdy", 32'(in_ready), 32'd1);
        in_rs1 = 32'd10; in_rs2 = 32'd20; in_rd_addr = 5'd2;
        step();  // B -> S
        chk("bp_b_rdy", 32'(in_ready), 32'd0);
        chk("bp_b_hold", out_result, 32'd3);
        in_op = 4'b0100; in_rs1 = 32'hF0; in_rs2 = 32'hFF; in_rd_addr = 5'd3;
        step();  // C stalled
        chk("bp_c_rdy", 32'(in_ready), 32'd0);
        chk("bp_c_hold", out_result, 32'd3);
        chk("bp_c_rd", 32'(out_rd_addr), 32'd1);
        chk("bp_c_cnt", op_count, 32'd0);
        out_ready = 1'b1;
        step();  // A out, B S->M
        chk("bp_r1_res", out_result, 32'd30);
        chk("bp_r1_rd", 32'(out_rd_addr), 32'd2);
        chk("bp_r1_rdy", 32'(in_ready), 32'd1);
        chk("bp_r1_cnt", op_count, 32'd1);
        step();  // B out, C accepted into M
        in_valid = 1'b0;
        chk("bp_r2_vld", 32'(out_valid), 32'd1);
        chk("bp_r2_res", out_result, 32'h0F);
        chk("bp_r2_rd", 32'(out_rd_addr), 32'd3);
        chk("bp_r2_cnt", op_count, 32'd2);
        step();  // C out
        chk("bp_end_vld", 32'(out_valid), 32'd0);
        chk("bp_end_cnt", op_count, 32'd3);

        // Reset with both M and S full
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'b0000; in_rs1 = 32'd7; in_rs2 = 32'd7; in_rd_addr = 5'd9;
        step();
        step();
        in_valid = 1'b0;
        chk("rf_full_rdy", 32'(in_ready), 32'd0);
        chk("rf_full_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rf_vld", 32'(out_valid), 32'd0);
        chk("rf_rdy", 32'(in_ready), 32'd1);
        chk("rf_cnt", op_count, 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rf_post1_vld", 32'(out_valid), 32'd0);
        step();
        chk("rf_post2_vld", 32'(out_valid), 32'd0);
        chk("rf_post_cnt", op_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
